// File: rtl/sdram_arbiter.sv
// sdram_arbiter
//   Two-master arbiter in front of a single pipelined SDRAM controller slave.
//   A request is granted from IDLE (round-robin on a tie), presented to the
//   slave from BUSY until accepted or withdrawn, and every accepted read
//   pushes the granting master's tag into an in-order FIFO so that pipelined
//   read returns can be routed back to the right master.
//
// Ports
//   clk, rst                  : clock, asynchronous active-high reset
//   mN_address/read/write     : master N request (N = 0, 1)
//   mN_writedata/byteenable   : master N write payload
//   mN_waitrequest            : master N stall
//   mN_readdata/readdatavalid : master N read return
//   s_address/read/write/...  : request towards the SDRAM controller
//   s_waitrequest             : slave stall
//   s_readdata/readdatavalid  : pipelined read return from the slave
//   err_unexpected            : sticky, read return seen with nothing outstanding
module sdram_arbiter #(
   parameter int AW    = 22,
   parameter int DW    = 16,
   parameter int DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst,

   input  logic [AW-1:0]     m0_address,
   input  logic              m0_read,
   input  logic              m0_write,
   input  logic [DW-1:0]     m0_writedata,
   input  logic [DW/8-1:0]   m0_byteenable,
   output logic              m0_waitrequest,
   output logic [DW-1:0]     m0_readdata,
   output logic              m0_readdatavalid,

   input  logic [AW-1:0]     m1_address,
   input  logic              m1_read,
   input  logic              m1_write,
   input  logic [DW-1:0]     m1_writedata,
   input  logic [DW/8-1:0]   m1_byteenable,
   output logic              m1_waitrequest,
   output logic [DW-1:0]     m1_readdata,
   output logic              m1_readdatavalid,

   output logic [AW-1:0]     s_address,
   output logic              s_read,
   output logic              s_write,
   output logic [DW-1:0]     s_writedata,
   output logic [DW/8-1:0]   s_byteenable,
   input  logic              s_waitrequest,
   input  logic [DW-1:0]     s_readdata,
   input  logic              s_readdatavalid,

   output logic              err_unexpected
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   typedef enum logic {IDLE, BUSY} state_t;

   state_t           state_q, state_d;
   logic             g_q, g_d;
   logic             last_grant_q, last_grant_d;
   logic [DEPTH-1:0] tag_q, tag_d;
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             err_q, err_d;

   logic             sel_read, sel_write;
   logic             m0_elig, m1_elig;
   logic             push, pop, head_tag, busy;

   always_comb begin
      sel_read  = g_q ? m1_read  : m0_read;
      sel_write = g_q ? m1_write : m0_write;

      m0_elig = m0_write | (m0_read & (cnt_q < CW'(DEPTH)));
      m1_elig = m1_write | (m1_read & (cnt_q < CW'(DEPTH)));

      state_d      = state_q;
      g_d          = g_q;
      last_grant_d = last_grant_q;
      push         = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (m0_elig | m1_elig) begin
               state_d = BUSY;
               if (m0_elig & m1_elig) g_d = ~last_grant_q;
               else                   g_d = m1_elig;
            end
         end
         BUSY: begin
            // A withdrawn request never reaches the slave, so it is not an
            // acceptance and must not move the round-robin pointer.
            if (!sel_read && !sel_write) begin
               state_d = IDLE;
            end else if (!s_waitrequest) begin
               state_d      = IDLE;
               last_grant_d = g_q;
               push         = sel_read & ~sel_write;
            end
         end
         default: state_d = IDLE;
      endcase

      pop      = s_readdatavalid & (cnt_q != '0);
      head_tag = tag_q[rd_ptr_q];

      tag_d = tag_q;
      if (push) tag_d[wr_ptr_q] = g_q;

      // Pointers are PW bits wide, so the increment wraps modulo DEPTH.
      wr_ptr_d = wr_ptr_q + PW'(push);
      rd_ptr_d = rd_ptr_q + PW'(pop);
      cnt_d    = cnt_q + CW'(push) - CW'(pop);
      err_d    = err_q | (s_readdatavalid & (cnt_q == '0));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         g_q          <= 1'b0;
         last_grant_q <= 1'b1;
         tag_q        <= '0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         cnt_q        <= '0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         g_q          <= g_d;
         last_grant_q <= last_grant_d;
         tag_q        <= tag_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         cnt_q        <= cnt_d;
         err_q        <= err_d;
      end
   end

   always_comb begin
      busy = (state_q == BUSY);

      s_address    = g_q ? m1_address    : m0_address;
      s_writedata  = g_q ? m1_writedata  : m0_writedata;
      s_byteenable = g_q ? m1_byteenable : m0_byteenable;
      s_write      = busy & sel_write;
      // Read+write together is a write; suppress the read strobe.
      s_read       = busy & sel_read & ~sel_write;

      m0_waitrequest = (busy & ~g_q) ? s_waitrequest : 1'b1;
      m1_waitrequest = (busy &  g_q) ? s_waitrequest : 1'b1;

      m0_readdata      = s_readdata;
      m1_readdata      = s_readdata;
      m0_readdatavalid = pop & ~head_tag;
      m1_readdatavalid = pop &  head_tag;

      err_unexpected = err_q;
   end

endmodule

// File: tb/tb_sdram_arbiter.sv
// tb_sdram_arbiter
//   Directed bench for sdram_arbiter. Expected slave transactions and read
//   returns are queued by the stimulus; two monitors pop and compare whenever
//   the DUT presents an accepted slave request or a master readdatavalid.
module tb_sdram_arbiter;

   localparam int AW    = 22;
   localparam int DW    = 16;
   localparam int DEPTH = 4;
   localparam int BW    = DW / 8;

   logic          clk = 1'b0;
   logic          rst = 1'b1;

   logic [AW-1:0] m0_address, m1_address;
   logic          m0_read, m0_write, m1_read, m1_write;
   logic [DW-1:0] m0_writedata, m1_writedata;
   logic [BW-1:0] m0_byteenable, m1_byteenable;
   logic          m0_waitrequest, m1_waitrequest;
   logic [DW-1:0] m0_readdata, m1_readdata;
   logic          m0_readdatavalid, m1_readdatavalid;

   logic [AW-1:0] s_address;
   logic          s_read, s_write;
   logic [DW-1:0] s_writedata;
   logic [BW-1:0] s_byteenable;
   logic          s_waitrequest;
   logic [DW-1:0] s_readdata;
   logic          s_readdatavalid;
   logic          err_unexpected;

   sdram_arbiter #(.AW(AW), .DW(DW), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst),
      .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
      .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable),
      .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
      .m0_readdatavalid(m0_readdatavalid),
      .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
      .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
      .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
      .m1_readdatavalid(m1_readdatavalid),
      .s_address(s_address), .s_read(s_read), .s_write(s_write),
      .s_writedata(s_writedata), .s_byteenable(s_byteenable),
      .s_waitrequest(s_waitrequest), .s_readdata(s_readdata),
      .s_readdatavalid(s_readdatavalid),
      .err_unexpected(err_unexpected)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit            wr;
      bit            m;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      logic [BW-1:0] be;
   } txn_t;

   typedef struct {
      bit            m;
      logic [DW-1:0] d;
   } ret_t;

   txn_t exp_q[$];
   ret_t ret_q[$];

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic exp_txn(input bit wr, input bit m, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input logic [BW-1:0] be);
      txn_t t;
      t.wr = wr; t.m = m; t.a = a;
      t.d  = wr ? d  : '0;
      t.be = wr ? be : '0;
      exp_q.push_back(t);
   endtask

   task automatic exp_ret(input bit m, input logic [DW-1:0] d);
      ret_t r;
      r.m = m; r.d = d;
      ret_q.push_back(r);
   endtask

   // Slave-side monitor: one comparison per accepted transfer.
   always @(negedge clk) begin
      if (!rst && (s_read || s_write) && !s_waitrequest) begin
         txn_t e;
         logic [63:0] act, expv;
         bit am;
         chk("grant_wait_onehot", 64'(m0_waitrequest ^ m1_waitrequest), 64'd1);
         am = m0_waitrequest;
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL slave_txn: got unexpected transfer addr %0h expected none", s_address);
         end else begin
            e    = exp_q.pop_front();
            act  = {22'd0, s_write, am, s_address, s_write ? s_writedata : 16'd0,
                    s_write ? s_byteenable : 2'd0};
            expv = {22'd0, e.wr, e.m, e.a, e.d, e.be};
            chk("slave_txn", act, expv);
         end
      end
   end

   // Read-return monitor.
   always @(negedge clk) begin
      if (m0_readdatavalid || m1_readdatavalid) begin
         ret_t e;
         chk("rdv_onehot", 64'(m0_readdatavalid & m1_readdatavalid), 64'd0);
         if (ret_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL read_return: got valid m0=%0d m1=%0d expected none",
                     m0_readdatavalid, m1_readdatavalid);
         end else begin
            e = ret_q.pop_front();
            chk("read_return", {47'd0, m1_readdatavalid,
                                m1_readdatavalid ? m1_readdata : m0_readdata},
                {47'd0, e.m, e.d});
         end
      end
   end

   // Holds a master request until it is accepted (Avalon style).
   task automatic drive(input bit n, input bit wr, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input logic [BW-1:0] be);
      bit done = 1'b0;
      int cyc  = 0;
      if (n == 1'b0) begin
         m0_address = a; m0_writedata = d; m0_byteenable = be;
         m0_write = wr; m0_read = ~wr;
      end else begin
         m1_address = a; m1_writedata = d; m1_byteenable = be;
         m1_write = wr; m1_read = ~wr;
      end
      while (!done && cyc < 100) begin
         @(negedge clk);
         if ((n == 1'b0 ? m0_waitrequest : m1_waitrequest) == 1'b0) done = 1'b1;
         tick();
         cyc++;
      end
      if (n == 1'b0) begin m0_write = 1'b0; m0_read = 1'b0; end
      else           begin m1_write = 1'b0; m1_read = 1'b0; end
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL drive_timeout: got no accept for m%0d addr %0h expected accept", n, a);
      end
   endtask

   task automatic pulse_rdv(input logic [DW-1:0] d);
      s_readdatavalid = 1'b1;
      s_readdata      = d;
      tick();
      s_readdatavalid = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      m0_address = '0; m0_read = 0; m0_write = 0; m0_writedata = '0; m0_byteenable = '0;
      m1_address = '0; m1_read = 0; m1_write = 0; m1_writedata = '0; m1_byteenable = '0;
      s_waitrequest = 0; s_readdata = '0; s_readdatavalid = 0;

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_s_read",  64'(s_read), 64'd0);
      chk("rst_s_write", 64'(s_write), 64'd0);
      chk("rst_wait",    64'({m0_waitrequest, m1_waitrequest}), 64'd3);
      chk("rst_rdv",     64'({m0_readdatavalid, m1_readdatavalid}), 64'd0);
      chk("rst_err",     64'(err_unexpected), 64'd0);
      tick();
      rst = 1'b0;
      tick();

      // Single write, minimum latency
      exp_txn(1, 0, 22'h000010, 16'hBEEF, 2'b11);
      m0_address = 22'h000010; m0_writedata = 16'hBEEF; m0_byteenable = 2'b11; m0_write = 1;
      @(negedge clk);
      chk("wr_c0_s_write", 64'(s_write), 64'd0);
      chk("wr_c0_wait",    64'(m0_waitrequest), 64'd1);
      tick();
      @(negedge clk);
      chk("wr_c1_s_write", 64'(s_write), 64'd1);
      chk("wr_c1_addr",    64'(s_address), 64'h10);
      chk("wr_c1_data",    64'(s_writedata), 64'hBEEF);
      chk("wr_c1_wait",    64'(m0_waitrequest), 64'd0);
      tick();
      m0_write = 0;
      @(negedge clk);
      chk("wr_c2_idle",    64'(s_write), 64'd0);
      chk("wr_c2_wait",    64'(m0_waitrequest), 64'd1);
      tick();

      // Round-robin from reset: m0, m1, m0, m1
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tick();
      exp_txn(0, 0, 22'h100, '0, '0);
      exp_txn(0, 1, 22'h200, '0, '0);
      exp_txn(0, 0, 22'h101, '0, '0);
      exp_txn(0, 1, 22'h201, '0, '0);
      fork
         begin drive(0, 0, 22'h100, '0, '0); drive(0, 0, 22'h101, '0, '0); end
         begin drive(1, 0, 22'h200, '0, '0); drive(1, 0, 22'h201, '0, '0); end
      join
      exp_ret(0, 16'hA001); exp_ret(1, 16'hA002); exp_ret(0, 16'hA003); exp_ret(1, 16'hA004);
      pulse_rdv(16'hA001); pulse_rdv(16'hA002); pulse_rdv(16'hA003); pulse_rdv(16'hA004);

      // FIFO full: 5th m1 read stalls while m0 write proceeds
      for (int i = 0; i < 4; i++) begin
         exp_txn(0, 1, 22'h300 + 22'(i), '0, '0);
         drive(1, 0, 22'h300 + 22'(i), '0, '0);
      end
      m1_address = 22'h304; m1_read = 1;
      repeat (3) begin
         @(negedge clk);
         chk("full_m1_wait", 64'(m1_waitrequest), 64'd1);
         chk("full_s_read",  64'(s_read), 64'd0);
      end
      tick();
      exp_txn(1, 0, 22'h050, 16'hA5A5, 2'b11);
      drive(0, 1, 22'h050, 16'hA5A5, 2'b11);
      exp_txn(0, 1, 22'h304, '0, '0);
      @(negedge clk);
      chk("full_still_stalled", 64'({s_read, m1_waitrequest}), 64'd1);
      tick();
      exp_ret(1, 16'hC0DE);
      s_readdatavalid = 1; s_readdata = 16'hC0DE;
      @(negedge clk);
      chk("pop_cycle_wait", 64'(m1_waitrequest), 64'd1);
      tick();
      s_readdatavalid = 0;
      @(negedge clk);
      chk("after_pop_c0", 64'(s_read), 64'd0);
      tick();
      @(negedge clk);
      chk("after_pop_c1_read", 64'(s_read), 64'd1);
      chk("after_pop_c1_addr", 64'(s_address), 64'h304);
      chk("after_pop_c1_wait", 64'(m1_waitrequest), 64'd0);
      tick();
      m1_read = 0;
      for (int i = 0; i < 4; i++) begin
         exp_ret(1, 16'hB000 + 16'(i));
         pulse_rdv(16'hB000 + 16'(i));
      end

      // Interleaved reads m0, m1, m0 routed in order
      exp_txn(0, 0, 22'h400, '0, '0); drive(0, 0, 22'h400, '0, '0);
      exp_txn(0, 1, 22'h401, '0, '0); drive(1, 0, 22'h401, '0, '0);
      exp_txn(0, 0, 22'h402, '0, '0); drive(0, 0, 22'h402, '0, '0);
      exp_ret(0, 16'h1111); exp_ret(1, 16'h2222); exp_ret(0, 16'h3333);
      pulse_rdv(16'h1111); pulse_rdv(16'h2222); pulse_rdv(16'h3333);
      @(negedge clk);
      chk("interleave_cnt", 64'(dut.cnt_q), 64'd0);
      chk("interleave_err", 64'(err_unexpected), 64'd0);
      tick();

      // Slave stall for 5 cycles during an m1 write
      s_waitrequest = 1;
      exp_txn(1, 1, 22'h555, 16'h1234, 2'b01);
      m1_address = 22'h555; m1_writedata = 16'h1234; m1_byteenable = 2'b01; m1_write = 1;
      @(negedge clk);
      chk("stall_c0", 64'(s_write), 64'd0);
      tick();
      for (int i = 1; i <= 5; i++) begin
         @(negedge clk);
         chk("stall_s", 64'({s_write, s_address, s_writedata, s_byteenable}),
             {23'd0, 1'b1, 22'h555, 16'h1234, 2'b01});
         chk("stall_wait", 64'({m0_waitrequest, m1_waitrequest}), 64'd3);
         tick();
      end
      s_waitrequest = 0;
      @(negedge clk);
      chk("stall_c6", 64'({s_write, m1_waitrequest, m0_waitrequest}), 64'b101);
      tick();
      m1_write = 0;
      @(negedge clk);
      chk("stall_done", 64'(s_write), 64'd0);
      tick();

      // Reset with two reads outstanding, then a stray return
      exp_txn(0, 0, 22'h600, '0, '0); drive(0, 0, 22'h600, '0, '0);
      exp_txn(0, 1, 22'h601, '0, '0); drive(1, 0, 22'h601, '0, '0);
      rst = 1;
      @(negedge clk);
      chk("midrst_err", 64'(err_unexpected), 64'd0);
      tick();
      rst = 0;
      tick();
      s_readdatavalid = 1; s_readdata = 16'hDEAD;
      @(negedge clk);
      chk("stray_rdv", 64'({m0_readdatavalid, m1_readdatavalid}), 64'd0);
      tick();
      s_readdatavalid = 0;
      @(negedge clk);
      chk("stray_err", 64'(err_unexpected), 64'd1);
      repeat (3) tick();
      @(negedge clk);
      chk("stray_err_sticky", 64'(err_unexpected), 64'd1);

      chk("exp_q_empty", 64'(exp_q.size()), 64'd0);
      chk("ret_q_empty", 64'(ret_q.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
